nonce_selector: RTL and testbench

- Downstream consumer of bitcoin_hash; runs after bitcoin_hash asserts done.
- Reads the NUM_NONCES final H0 words that bitcoin_hash wrote at output_addr (word i belongs to nonce i) over the shared memory port.
- Selects the best nonce (smallest H0, unsigned) and compares it against a difficulty target.
- Writes a two-word result record and reports the winner on ports.

---
 rtl/nonce_selector_if.sv | 27 ++
 rtl/nonce_selector.sv | 166 ++++++++++++++++
 tb/tb_nonce_selector.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/nonce_selector_if.sv
// Control, result and shared-memory signals between nonce_selector and its host.
// The slave modport is the selector side; master is the host/memory side.
interface nonce_selector_if;
   logic        start;
   logic [15:0] hash_addr;
   logic [15:0] result_addr;
   logic [31:0] target;
   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        done;
   logic        found;
   logic [31:0] best_nonce;
   logic [31:0] best_hash;

   modport slave (
      input  start, hash_addr, result_addr, target, mem_read_data,
      output mem_clk, mem_we, mem_addr, mem_write_data, done, found, best_nonce, best_hash
   );

   modport master (
      output start, hash_addr, result_addr, target, mem_read_data,
      input  mem_clk, mem_we, mem_addr, mem_write_data, done, found, best_nonce, best_hash
   );
endinterface

// File: rtl/nonce_selector.sv
// Scans NUM_NONCES H0 words, keeps the smallest (lowest index on ties), writes a 2-word record.
// Optional NONCE_SELECTOR_EARLY_EXIT_EN: stop at the first word that meets the target.
module nonce_selector #(
   parameter int NUM_NONCES = 16
) (
   input  logic            clk,
   input  logic            reset,
   nonce_selector_if.slave bus
);
   localparam logic [15:0] N_CNT  = 16'(NUM_NONCES);
   localparam logic [15:0] N_LAST = 16'(NUM_NONCES - 1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WR0, S_WR1, S_DONE} state_t;

   state_t      r_state, w_state_nxt;

   logic        r_mem_we,      w_mem_we;
   logic [15:0] r_mem_addr,    w_mem_addr;
   logic [31:0] r_mem_wdata,   w_mem_wdata;
   logic        r_done,        w_done;
   logic        r_found,       w_found;
   logic [15:0] r_best_nonce,  w_best_nonce;
   logic [31:0] r_best_hash,   w_best_hash;
   logic [15:0] r_res_addr,    w_res_addr;
   logic [31:0] r_target,      w_target;
   logic [15:0] r_iss_cnt,     w_iss_cnt;
   logic        r_iss_on,      w_iss_on;
   logic        r_rcv_vld,     w_rcv_vld;
   logic [15:0] r_rcv_idx,     w_rcv_idx;

   logic        w_hit;
   logic        w_last;
   logic        w_scan_end;

   // Index 0 always loads so an all-ones first word still claims nonce 0.
   assign w_hit  = r_rcv_vld && ((bus.mem_read_data < r_best_hash) || (r_rcv_idx == 16'd0));
   assign w_last = r_rcv_vld && (r_rcv_idx == N_LAST);
`ifdef NONCE_SELECTOR_EARLY_EXIT_EN
   assign w_scan_end = w_last || (r_rcv_vld && (bus.mem_read_data <= r_target));
`else
   assign w_scan_end = w_last;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_READ;
         S_READ:  if (w_scan_end) w_state_nxt = S_WR0;
         S_WR0:   w_state_nxt = S_WR1;
         S_WR1:   w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_mem_we     = 1'b0;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      w_done       = 1'b0;
      w_found      = r_found;
      w_best_nonce = r_best_nonce;
      w_best_hash  = r_best_hash;
      w_res_addr   = r_res_addr;
      w_target     = r_target;
      w_iss_cnt    = r_iss_cnt;
      w_iss_on     = r_iss_on;
      w_rcv_vld    = 1'b0;
      w_rcv_idx    = r_rcv_idx;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_mem_addr   = bus.hash_addr;
               w_res_addr   = bus.result_addr;
               w_target     = bus.target;
               w_iss_cnt    = 16'd1;
               w_iss_on     = 1'b1;
               w_rcv_idx    = 16'd0;
               w_best_hash  = 32'hFFFF_FFFF;
               w_best_nonce = 16'd0;
               w_found      = 1'b0;
            end
         end
         S_READ: begin
            // r_iss_on marks that the address currently on the bus is a real read.
            w_rcv_vld = r_iss_on;
            if (r_iss_on) begin
               if (r_iss_cnt == N_CNT) begin
                  w_iss_on = 1'b0;
               end else begin
                  w_mem_addr = r_mem_addr + 16'd1;
                  w_iss_cnt  = r_iss_cnt + 16'd1;
               end
            end
            if (r_rcv_vld) w_rcv_idx = r_rcv_idx + 16'd1;
            if (w_hit) begin
               w_best_hash  = bus.mem_read_data;
               w_best_nonce = r_rcv_idx;
            end
            if (w_scan_end) begin
               w_iss_on    = 1'b0;
               w_rcv_vld   = 1'b0;
               w_mem_we    = 1'b1;
               w_mem_addr  = r_res_addr;
               w_mem_wdata = {16'd0, w_best_nonce};
            end
         end
         S_WR0: begin
            w_found     = (r_best_hash <= r_target);
            w_mem_we    = 1'b1;
            w_mem_addr  = r_res_addr + 16'd1;
            w_mem_wdata = {31'd0, w_found};
         end
         S_WR1: begin
            w_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 16'd0;
         r_mem_wdata  <= 32'd0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_best_nonce <= 16'd0;
         r_best_hash  <= 32'hFFFF_FFFF;
         r_res_addr   <= 16'd0;
         r_target     <= 32'd0;
         r_iss_cnt    <= 16'd0;
         r_iss_on     <= 1'b0;
         r_rcv_vld    <= 1'b0;
         r_rcv_idx    <= 16'd0;
      end else begin
         r_mem_we     <= w_mem_we;
         r_mem_addr   <= w_mem_addr;
         r_mem_wdata  <= w_mem_wdata;
         r_done       <= w_done;
         r_found      <= w_found;
         r_best_nonce <= w_best_nonce;
         r_best_hash  <= w_best_hash;
         r_res_addr   <= w_res_addr;
         r_target     <= w_target;
         r_iss_cnt    <= w_iss_cnt;
         r_iss_on     <= w_iss_on;
         r_rcv_vld    <= w_rcv_vld;
         r_rcv_idx    <= w_rcv_idx;
      end
   end

   assign bus.mem_clk        = clk;
   assign bus.mem_we         = r_mem_we;
   assign bus.mem_addr       = r_mem_addr;
   assign bus.mem_write_data = r_mem_wdata;
   assign bus.done           = r_done;
   assign bus.found          = r_found;
   assign bus.best_nonce     = {16'd0, r_best_nonce};
   assign bus.best_hash      = r_best_hash;
endmodule

// File: tb/tb_nonce_selector.sv
// Bench for nonce_selector: directed cases plus randomized scans against a behavioural model.
module tb_nonce_selector;
   localparam int N = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nonce_selector_if u_if();
   nonce_selector #(.NUM_NONCES(N)) dut (.clk(clk), .reset(reset), .bus(u_if.slave));

   logic [31:0] mem [0:65535];
   int          wr_cnt = 0;
   logic [15:0] wa [0:255];
   logic [31:0] wd [0:255];

   // Synchronous read memory; DUT writes are logged rather than stored.
   always @(posedge clk) begin
      u_if.mem_read_data <= mem[u_if.mem_addr];
      if (u_if.mem_we) begin
         wa[wr_cnt % 256] <= u_if.mem_addr;
         wd[wr_cnt % 256] <= u_if.mem_write_data;
         wr_cnt <= wr_cnt + 1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [15:0] h, input logic [31:0] base);
      for (int i = 0; i < N; i++) mem[16'(h + 16'(i))] = base + 32'(i);
   endtask

   // Reference: smallest word wins, earliest index on ties; early exit takes first qualifier.
   task automatic model(input logic [15:0] h, input logic [31:0] tgt,
                        output logic [31:0] bn, output logic [31:0] bh, output logic fnd,
                        output int lat, output int maxoff);
      logic [31:0] w;
      bh = 32'hFFFF_FFFF; bn = 0; lat = N + 4; maxoff = N - 1;
      for (int i = 0; i < N; i++) begin
         w = mem[16'(h + 16'(i))];
         if (i == 0 || w < bh) begin bh = w; bn = 32'(i); end
`ifdef NONCE_SELECTOR_EARLY_EXIT_EN
         if (w <= tgt) begin
            bh = w; bn = 32'(i); lat = i + 5;
            maxoff = (i + 1 < N - 1) ? i + 1 : N - 1;
            break;
         end
`endif
      end
      fnd = (bh <= tgt);
   endtask

   task automatic run_scan(input string nm, input logic [15:0] h, input logic [15:0] r,
                           input logic [31:0] tgt, input int spur);
      logic [31:0] ebn, ebh;
      logic        efnd;
      int          elat, emax, cnt, maxo, w0;
      logic [15:0] off;
      model(h, tgt, ebn, ebh, efnd, elat, emax);
      w0 = wr_cnt;
      @(posedge clk); #1;
      u_if.start = 1'b1; u_if.hash_addr = h; u_if.result_addr = r; u_if.target = tgt;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      cnt = 1; maxo = 0;
      while (!u_if.done && cnt < 200) begin
         if (!u_if.mem_we) begin
            off = u_if.mem_addr - h;
            if (int'(off) > maxo) maxo = int'(off);
         end
         if (spur != 0 && cnt == spur) begin
            u_if.start = 1'b1; u_if.hash_addr = h + 16'h1000; u_if.target = 32'd0;
         end else begin
            u_if.start = 1'b0;
         end
         @(posedge clk); #1;
         cnt++;
      end
      u_if.start = 1'b0;
      chk({nm, ".latency"}, 32'(cnt), 32'(elat));
      chk({nm, ".best_nonce"}, u_if.best_nonce, ebn);
      chk({nm, ".best_hash"}, u_if.best_hash, ebh);
      chk({nm, ".found"}, {31'd0, u_if.found}, {31'd0, efnd});
      chk({nm, ".nwrites"}, 32'(wr_cnt - w0), 32'd2);
      chk({nm, ".rec0_addr"}, {16'd0, wa[w0 % 256]}, {16'd0, r});
      chk({nm, ".rec0_data"}, wd[w0 % 256], ebn);
      chk({nm, ".rec1_addr"}, {16'd0, wa[(w0 + 1) % 256]}, {16'd0, 16'(r + 16'd1)});
      chk({nm, ".rec1_data"}, wd[(w0 + 1) % 256], {31'd0, efnd});
      chk({nm, ".max_rd_off"}, 32'(maxo), 32'(emax));
      @(posedge clk); #1;
      chk({nm, ".done_pulse"}, {31'd0, u_if.done}, 32'd0);
   endtask

   task automatic reset_abort;
      int w0;
      int seen_done;
      fill(16'h0200, 32'h3000_0000);
      mem[16'h0201] = 32'h0000_0005;
      w0 = wr_cnt;
      seen_done = 0;
      @(posedge clk); #1;
      u_if.start = 1'b1; u_if.hash_addr = 16'h0200; u_if.result_addr = 16'h0300;
      u_if.target = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      for (int k = 1; k < 6; k++) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_abort.mem_we", {31'd0, u_if.mem_we}, 32'd0);
      chk("rst_abort.done", {31'd0, u_if.done}, 32'd0);
      chk("rst_abort.best_hash", u_if.best_hash, 32'hFFFF_FFFF);
      chk("rst_abort.best_nonce", u_if.best_nonce, 32'd0);
      chk("rst_abort.mem_addr", {16'd0, u_if.mem_addr}, 32'd0);
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (u_if.done) seen_done++;
      end
      chk("rst_abort.nwrites", 32'(wr_cnt - w0), 32'd0);
      chk("rst_abort.no_done", 32'(seen_done), 32'd0);
   endtask

   initial begin
      logic [15:0] h;
      logic [31:0] tgt;
      for (int a = 0; a < 65536; a++) mem[a] = 32'd0;
      reset = 1'b1;
      u_if.start = 1'b0; u_if.hash_addr = 16'd0; u_if.result_addr = 16'd0; u_if.target = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.mem_we", {31'd0, u_if.mem_we}, 32'd0);
      chk("rst.mem_addr", {16'd0, u_if.mem_addr}, 32'd0);
      chk("rst.mem_wdata", u_if.mem_write_data, 32'd0);
      chk("rst.done", {31'd0, u_if.done}, 32'd0);
      chk("rst.found", {31'd0, u_if.found}, 32'd0);
      chk("rst.best_nonce", u_if.best_nonce, 32'd0);
      chk("rst.best_hash", u_if.best_hash, 32'hFFFF_FFFF);
      chk("rst.mem_clk", {31'd0, u_if.mem_clk}, {31'd0, clk});
      reset = 1'b0;

      fill(16'h0030, 32'h1000_0000);
      mem[16'h0037] = 32'h0000_0042;
      run_scan("t1_min", 16'h0030, 16'h0100, 32'h0000_1000, 0);

      for (int i = 0; i < N; i++) mem[16'h0400 + 16'(i)] = 32'h8000_0000;
      run_scan("t2_ties", 16'h0400, 16'h0500, 32'h0000_FFFF, 0);

      fill(16'h0600, 32'h7000_0000);
      mem[16'h0605] = 32'h0000_0003;
      mem[16'h060B] = 32'h0000_0003;
      run_scan("t3_eq", 16'h0600, 16'h0680, 32'h0000_0003, 0);

      fill(16'hFFF8, 32'h5000_0000);
      mem[16'h0001] = 32'h0000_0020;
      run_scan("t4_wrap", 16'hFFF8, 16'h0100, 32'h0000_0010, 0);

      reset_abort();
      run_scan("t5_recover", 16'h0200, 16'h0300, 32'h0000_0004, 0);

      fill(16'h0800, 32'h6000_0000);
      mem[16'h0803] = 32'h0000_0002;
      run_scan("t5_spur", 16'h0800, 16'h0900, 32'h0000_0010, 3);

      fill(16'h0700, 32'h9000_0000);
      mem[16'h0702] = 32'h0000_0001;
      run_scan("t6_early", 16'h0700, 16'h0780, 32'h0000_0010, 0);

      for (int t = 0; t < 10; t++) begin
         h = 16'($urandom);
         for (int i = 0; i < N; i++)
            mem[16'(h + 16'(i))] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         tgt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         run_scan($sformatf("rnd%0d", t), h, 16'(h + 16'h2000), tgt, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
